data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder_pkg.sv | 21 ++
 rtl/dsram_array.sv | 46 ++++
 rtl/data_sram_responder.sv | 126 ++++++++++++
 tb/tb_data_sram_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-side SRAM responder and its storage array.
package data_sram_responder_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } dsram_state_e;

    localparam int unsigned DSRAM_ADDR_W = 14;

    // en + wen + addr + wdata as presented on the data_sram_* interface
    localparam int unsigned DSRAM_REQ_W = 1 + 4 + 32 + 32;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dsram_req_t;

endpackage

// File: rtl/dsram_array.sv
// Four byte-wide lanes sharing one address: per-lane write enables plus one registered read port.
module dsram_array #(
    parameter int unsigned AddrW = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       we_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);
    localparam int unsigned Depth = 1 << AddrW;

    logic [3:0][7:0] lane_rd;
    logic [31:0]     rdata_q, rdata_d;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [Depth];

        always_ff @(posedge clk) begin
            if (we_i[i]) begin
                mem[addr_i] <= wdata_i[8*i +: 8];
            end
        end

        assign lane_rd[i] = mem[addr_i];
    end

    // Only the output register is reset; array contents persist across reset.
    always_comb begin
        rdata_d = rdata_q;
        if (rst) begin
            rdata_d = '0;
        end else if (re_i) begin
            rdata_d = lane_rd;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Memory end of the data_sram_* interface. Define DSRAM_WAIT_EN to build the wait-state
// engine that stretches each access by LATENCY cycles and raises stallreq meanwhile.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = DSRAM_ADDR_W,
    parameter int unsigned LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);
    logic              exec;
    logic [3:0]        exec_wen;
    logic [ADDR_W-1:0] exec_idx;
    logic [31:0]       exec_wdata;
    logic [3:0]        arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] req_idx;
    logic              unused_addr;

    // Bits outside the word index are ignored, so higher addresses alias.
    assign req_idx     = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DSRAM_WAIT_EN
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dsram_state_e      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        req_wen_q, req_wen_d;
    logic [ADDR_W-1:0] req_idx_q, req_idx_d;
    logic [31:0]       req_wdata_q, req_wdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_wen_d   = req_wen_q;
        req_idx_d   = req_idx_q;
        req_wdata_d = req_wdata_q;
        stallreq    = 1'b0;
        exec        = 1'b0;
        exec_wen    = data_sram_wen;
        exec_idx    = req_idx;
        exec_wdata  = data_sram_wdata;

        if (LATENCY == 0) begin
            exec = data_sram_en;
        end else begin
            unique case (state_q)
                StIdle: begin
                    stallreq = data_sram_en;
                    if (data_sram_en) begin
                        req_wen_d   = data_sram_wen;
                        req_idx_d   = req_idx;
                        req_wdata_d = data_sram_wdata;
                        cnt_d       = CntW'(LATENCY - 1);
                        state_d     = StWait;
                    end
                end
                StWait: begin
                    // Live requester inputs are ignored here; only the captured copy executes.
                    stallreq   = (cnt_q != '0);
                    exec_wen   = req_wen_q;
                    exec_idx   = req_idx_q;
                    exec_wdata = req_wdata_q;
                    if (cnt_q == '0) begin
                        exec    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_wen_q   <= '0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_wen_q   <= req_wen_d;
            req_idx_q   <= req_idx_d;
            req_wdata_q <= req_wdata_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^LATENCY;
    assign stallreq   = 1'b0;
    assign exec       = data_sram_en;
    assign exec_wen   = data_sram_wen;
    assign exec_idx   = req_idx;
    assign exec_wdata = data_sram_wdata;
`endif

    // Reset wins over any access executing on the same edge.
    assign arr_we = (exec && !rst) ? exec_wen : 4'b0000;
    assign arr_re = exec && !rst && (exec_wen == 4'b0000);

    dsram_array #(
        .AddrW(ADDR_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .addr_i (exec_idx),
        .wdata_i(exec_wdata),
        .rdata_o(data_sram_rdata)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench for data_sram_responder against a word-array reference model.
module tb_data_sram_responder;
    localparam int unsigned AddrW = 14;
`ifdef DSRAM_WAIT_EN
    localparam int unsigned Lat = 3;
`else
    localparam int unsigned Lat = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stallreq;

    data_sram_responder #(
        .ADDR_W (AddrW),
        .LATENCY(Lat)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (en),
        .data_sram_wen  (wen),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .stallreq       (stallreq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [int unsigned];
    logic [31:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic void model_access(input logic [3:0] w, input logic [31:0] a,
                                         input logic [31:0] d);
        int unsigned idx;
        logic [31:0] word;
        idx = (a >> 2) % (32'd1 << AddrW);
        word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        if (w == 4'b0000) begin
            exp_rdata = word;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w[i]) word[8*i +: 8] = d[8*i +: 8];
            end
            model_mem[idx] = word;
        end
    endfunction

    task automatic scramble_inputs();
        addr  = $urandom;
        wdata = $urandom;
        wen   = 4'($urandom);
    endtask

    // One access: counts stall cycles from the request cycle, then checks the read register.
    task automatic access(input string tag, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d);
        int stalls = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        en = 1'b1; wen = w; addr = a; wdata = d;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (stallreq) begin
                stalls++;
                @(posedge clk); #1;
                scramble_inputs();
            end else begin
                done = 1'b1;
            end
        end
        check({tag, ":stalls"}, 32'(stalls), 32'(Lat));
        @(posedge clk); #1;
        en = 1'b0;
        scramble_inputs();
        model_access(w, a, d);
        @(negedge clk);
        check({tag, ":rdata"}, rdata, exp_rdata);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        en = 1'b0;
        scramble_inputs();
        @(negedge clk);
        check("idle_hold", rdata, exp_rdata);
        check("idle_stall", 32'(stallreq), 32'd0);
    endtask

    logic [13:0] words [8];

    initial begin
        words = '{14'h0000, 14'h0001, 14'h0002, 14'h0003, 14'h0004, 14'h0008, 14'h3ffe, 14'h3fff};
        rst = 1'b1; en = 1'b0; wen = '0; addr = '0; wdata = '0;
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_stall", 32'(stallreq), 32'd0);
        idle_cycle();

        foreach (words[i]) access("preload", 4'hF, 32'(words[i]) << 2, $urandom);

        access("full_wr", 4'b1111, 32'h10, 32'hDEADBEEF);
        access("full_rd", 4'b0000, 32'h10, 32'h0);
        check("full_rd_const", rdata, 32'hDEADBEEF);
        access("part_wr1", 4'b0010, 32'h10, 32'h0000AA00);
        access("part_rd1", 4'b0000, 32'h10, 32'h0);
        check("part_rd1_const", rdata, 32'hDEADAAEF);
        access("part_wr2", 4'b1100, 32'h10, 32'h12340000);
        access("part_rd2", 4'b0000, 32'h10, 32'h0);
        check("part_rd2_const", rdata, 32'h1234AAEF);
        idle_cycle();

        access("alias_wr", 4'b1111, 32'h0001_0010, 32'h5A5A5A5A);
        access("alias_rd", 4'b0000, 32'h10, 32'h0);
        check("alias_rd_const", rdata, 32'h5A5A5A5A);
        access("alias_rd13", 4'b0000, 32'h13, 32'h0);
        check("alias_rd13_const", rdata, 32'h5A5A5A5A);

`ifdef DSRAM_WAIT_EN
        access("mr_pre", 4'b1111, 32'h20, 32'h0);
        @(posedge clk); #1;
        en = 1'b1; wen = 4'b1111; addr = 32'h20; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("mr_req_stall", 32'(stallreq), 32'd1);
        @(posedge clk); #1;
        addr = 32'h40;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
        check("mr_stall_drop", 32'(stallreq), 32'd0);
        check("mr_rdata_clr", rdata, 32'h0);
        access("mr_read", 4'b0000, 32'h20, 32'h0);
        check("mr_read_const", rdata, 32'h0);
`endif

        for (int n = 0; n < 50; n++) begin
            logic [31:0] a;
            logic [3:0]  w;
            a = ($urandom & 32'hFFFF_0003) | (32'(words[$urandom_range(0, 7)]) << 2);
            w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            access("rand", w, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
